ca_migration_controller: RTL and testbench
==========================================

Name: ca_migration_controller

Overview:
- Sequencer that drives a ring of binary cellular-automaton islands.
- Broadcasts a seed and loads it into every island, then clocks the islands for a fixed number of generations per epoch.
- Between epochs it pulses the migrate/load pair so each island reloads from its ring neighbour's state.
- After the last epoch it folds all island states into one XOR digest.
- Acts as the initiator side of the island interface (ce, load, migrate, set); the CA islands are the responders.

Parameters:
- Width, 16, cell count per island; width of seed, set_out and result.
- Islands, 4, number of islands whose state is collected; range 1..16.
- Steps, 10, generations (ca_ce cycles) per epoch; must be >= 1.
- Epochs, 10, epochs per run; range 1..255.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  request a run; sampled only in IDLE.
- abort  in  1  synchronous cancel; returns to IDLE from any state.
- seed  in  Width  initial configuration; latched on an accepted start.
- island_state  in  Islands*Width  concatenated island states; island 0 in the LSBs.
- set_out  out  Width  seed broadcast to islands when migrate=0.
- ca_load  out  1  islands load their set input on this edge.
- ca_ce  out  1  islands advance one generation on this edge.
- migrate  out  1  islands select their neighbour's state instead of set_out.
- epoch  out  8  current epoch index, 0-based.
- busy  out  1  high in SEED, RUN, MIGRATE and DONE.
- done  out  1  one-cycle completion pulse.
- result  out  Width  XOR of all island states at end of run.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; all outputs 0, including set_out, result and epoch. Counters cleared.
- All outputs are registered or decoded from registered state only; no combinational path from inputs to outputs.
- IDLE:
  - ca_load=ca_ce=migrate=0.
  - On start=1: set_out<=seed, epoch<=0, go to SEED.
- SEED (1 cycle): ca_load=1, migrate=0. Then RUN with step counter 0.
- RUN:
  - ca_ce=1 every cycle; step counter increments.
  - On the cycle with step==Steps-1: go to DONE if epoch==Epochs-1, otherwise go to MIGRATE.
- MIGRATE (1 cycle):
  - ca_load=1, migrate=1, ca_ce=0.
  - epoch increments on exit; step counter is cleared; go to RUN.
- DONE (1 cycle):
  - All strobes 0.
  - On exit edge: result <= XOR over i of island_state[i*Width +: Width]; done<=1 for exactly one cycle; go to IDLE.
- Strobe exclusivity: ca_ce and ca_load are never high together. migrate is high only together with ca_load.
- Timing: with start sampled at edge 0, SEED occupies cycle 1.
  - DONE occupies cycle 1 + Epochs*Steps + (Epochs-1) + 1.
  - done is high in the following cycle.
  - Epochs=1 means no MIGRATE state is entered.
- start while busy: ignored; set_out is unchanged.
- start in the cycle done is high: the controller is already in IDLE, so the start is accepted.
- abort (synchronous, priority over start): next state is IDLE, strobes drop the next cycle, no done pulse. result keeps its previous value; epoch is cleared.
- Asynchronous reset mid-run: immediate return to IDLE with every output 0, including result.
- result holds until the next completed run or reset.

Test Plan:
- Reset: hold rst=0 for 3 cycles with start=1 -> all outputs 0, busy=0; nothing starts until rst=1.
- Default parameters, seed=16'hA5C3:
  - set_out=16'hA5C3 from cycle 1.
  - ca_load in cycle 1; ca_ce high in exactly 100 cycles.
  - 9 migrate pulses, each coincident with ca_load.
  - epoch runs 0..9; done pulse in cycle 112; busy falls in cycle 112.
- Steps=3, Epochs=1 -> cycle sequence SEED, RUN×3, DONE; migrate never asserted; done in cycle 6.
- Digest: island_state={16'hF000,16'h0F00,16'h00F0,16'h000F} held constant -> result=16'hFFFF with done. Then all-equal states 16'h1234 (4 islands) -> result=16'h0000.
- start pulsed in RUN with seed=16'hFFFF -> ignored, set_out stays 16'hA5C3. start coincident with done -> new SEED cycle the next cycle.
- abort in the 5th RUN cycle of epoch 2 -> ca_ce=0 next cycle, state IDLE, no done, result unchanged. rst=0 asynchronously during MIGRATE -> all outputs 0 before the next clk edge.

Source files
------------

// File: rtl/ca_island_if.sv
// Island-ring bus between the migration controller (master) and the CA islands (slaves).
interface ca_island_if #(
  parameter int unsigned Width   = 16,
  parameter int unsigned Islands = 4
);
  logic [Width-1:0]         set_out;
  logic                     ca_load;
  logic                     ca_ce;
  logic                     migrate;
  logic [Islands*Width-1:0] island_state;

  modport master (
    output set_out, ca_load, ca_ce, migrate,
    input  island_state
  );

  modport slave (
    input  set_out, ca_load, ca_ce, migrate,
    output island_state
  );
endinterface

// File: rtl/ca_migration_controller.sv
// Seeds a ring of CA islands, runs Epochs x Steps generations with neighbour migration
// between epochs, then folds the island states into one XOR digest.
module ca_migration_controller #(
  parameter int unsigned Width   = 16,
  parameter int unsigned Islands = 4,
  parameter int unsigned Steps   = 10,
  parameter int unsigned Epochs  = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [Width-1:0] seed,
  ca_island_if.master      isl,
  output logic [7:0]       epoch,
  output logic             busy,
  output logic             done,
  output logic [Width-1:0] result
);

  localparam logic [2:0] StIdle    = 3'd0;
  localparam logic [2:0] StSeed    = 3'd1;
  localparam logic [2:0] StRun     = 3'd2;
  localparam logic [2:0] StMigrate = 3'd3;
  localparam logic [2:0] StDone    = 3'd4;

  localparam int unsigned StepW = (Steps > 1) ? $clog2(Steps) : 1;
  localparam logic [StepW-1:0] LastStep  = StepW'(Steps - 1);
  localparam logic [7:0]       LastEpoch = 8'(Epochs - 1);

  logic [2:0]       state_q, state_d;
  logic [StepW-1:0] step_q, step_d;
  logic [7:0]       epoch_q, epoch_d;
  logic [Width-1:0] set_q, set_d;
  logic [Width-1:0] result_q, result_d;
  logic             done_q, done_d;
  logic [Width-1:0] digest;

  always_comb begin
    digest = '0;
    for (int unsigned i = 0; i < Islands; i++) begin
      digest = digest ^ isl.island_state[i*Width +: Width];
    end
  end

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    epoch_d  = epoch_q;
    set_d    = set_q;
    result_d = result_q;
    done_d   = 1'b0;
    if (abort) begin
      // Cancel keeps the seed and the last digest; only the sequencing is cleared.
      state_d = StIdle;
      step_d  = '0;
      epoch_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            set_d   = seed;
            epoch_d = '0;
            state_d = StSeed;
          end
        end
        StSeed: begin
          step_d  = '0;
          state_d = StRun;
        end
        StRun: begin
          step_d = step_q + StepW'(1);
          if (step_q == LastStep) begin
            state_d = (epoch_q == LastEpoch) ? StDone : StMigrate;
          end
        end
        StMigrate: begin
          epoch_d = epoch_q + 8'd1;
          step_d  = '0;
          state_d = StRun;
        end
        StDone: begin
          result_d = digest;
          done_d   = 1'b1;
          state_d  = StIdle;
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= StIdle;
      step_q   <= '0;
      epoch_q  <= '0;
      set_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      epoch_q  <= epoch_d;
      set_q    <= set_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  // Strobes decode from the state register only, so they can never overlap.
  assign isl.set_out = set_q;
  assign isl.ca_load = (state_q == StSeed) || (state_q == StMigrate);
  assign isl.ca_ce   = (state_q == StRun);
  assign isl.migrate = (state_q == StMigrate);
  assign busy        = (state_q != StIdle);
  assign epoch       = epoch_q;
  assign done        = done_q;
  assign result      = result_q;

endmodule

// File: tb/tb_ca_migration_controller.sv
// Self-checking bench for ca_migration_controller: cycle-level schedule model driven by
// randomized island states, plus a short-run instance with Steps=3, Epochs=1.
module tb_ca_migration_controller;
  localparam int unsigned W = 16;
  localparam int unsigned N = 4;
  localparam int S = 10;
  localparam int E = 10;
  localparam int TDone = E * S + E + 1;  // cycle index of DONE after the start edge

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] seed = '0;
  logic [7:0]   epoch;
  logic         busy, done;
  logic [W-1:0] result;

  logic         start2 = 1'b0;
  logic         abort2 = 1'b0;
  logic [W-1:0] seed2 = '0;
  logic [7:0]   epoch2;
  logic         busy2, done2;
  logic [W-1:0] result2;

  int checks = 0;
  int errors = 0;

  ca_island_if #(.Width(W), .Islands(N)) isl ();
  ca_island_if #(.Width(W), .Islands(N)) isl2 ();

  ca_migration_controller #(.Width(W), .Islands(N), .Steps(S), .Epochs(E)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .seed(seed), .isl(isl),
    .epoch(epoch), .busy(busy), .done(done), .result(result)
  );

  ca_migration_controller #(.Width(W), .Islands(N), .Steps(3), .Epochs(1)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .seed(seed2), .isl(isl2),
    .epoch(epoch2), .busy(busy2), .done(done2), .result(result2)
  );

  always #5 clk = ~clk;

  // Reference model: position in the run schedule plus the architectural registers.
  bit           m_active = 1'b0;
  int           m_t = 0;
  bit           m_done = 1'b0;
  logic [7:0]   m_epoch = '0;
  logic [W-1:0] m_set = '0;
  logic [W-1:0] m_result = '0;

  function automatic logic [W-1:0] fold(input logic [N*W-1:0] v);
    logic [W-1:0] r = '0;
    for (int i = 0; i < int'(N); i++) r = r ^ v[i*W +: W];
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    logic         p_start, p_abort;
    logic [W-1:0] p_seed;
    logic [N*W-1:0] p_isl;
    p_start = start;
    p_abort = abort;
    p_seed  = seed;
    p_isl   = isl.island_state;
    @(posedge clk);
    #1;
    m_done = 1'b0;
    if (!rst) begin
      m_active = 1'b0; m_t = 0; m_epoch = '0; m_set = '0; m_result = '0;
    end else if (p_abort) begin
      m_active = 1'b0; m_t = 0; m_epoch = '0;
    end else if (m_active) begin
      if (m_t == TDone) begin
        m_active = 1'b0; m_t = 0; m_done = 1'b1; m_result = fold(p_isl);
      end else begin
        m_t++;
        if (m_t >= 2 && m_t < TDone) m_epoch = 8'((m_t - 2) / (S + 1));
      end
    end else if (p_start) begin
      m_active = 1'b1; m_t = 1; m_set = p_seed; m_epoch = '0;
    end
  endtask

  task automatic check_cycle();
    bit in_body, ld, ce, mg;
    in_body = m_active && m_t >= 2 && m_t < TDone;
    ce = in_body && ((m_t - 2) % (S + 1)) < S;
    mg = in_body && ((m_t - 2) % (S + 1)) == S;
    ld = mg || (m_active && m_t == 1);
    chk("ca_load", 32'(isl.ca_load), 32'(ld));
    chk("ca_ce", 32'(isl.ca_ce), 32'(ce));
    chk("migrate", 32'(isl.migrate), 32'(mg));
    chk("busy", 32'(busy), 32'(m_active));
    chk("done", 32'(done), 32'(m_done));
    chk("epoch", 32'(epoch), 32'(m_epoch));
    chk("set_out", 32'(isl.set_out), 32'(m_set));
    chk("result", 32'(result), 32'(m_result));
    chk("ce_load_excl", 32'(isl.ca_ce & isl.ca_load), 32'(0));
  endtask

  // Runs from inside a started run until done; start (seed 16'hFFFF) pulses at schedule
  // position inject_t to probe that starts during a run are ignored.
  task automatic run_to_done(input bit rand_isl, input int inject_t,
                             output int done_cyc, output int nce, output int nmg);
    bit seen = 1'b0;
    done_cyc = -1; nce = 0; nmg = 0;
    for (int k = 0; k < 200 && !seen; k++) begin
      if (rand_isl) isl.island_state = {$urandom, $urandom};
      start = m_active && (m_t == inject_t);
      if (start) seed = 16'hFFFF;
      tick();
      check_cycle();
      if (isl.ca_ce) nce++;
      if (isl.migrate) nmg++;
      if (done) begin
        seen = 1'b1;
        done_cyc = k + 2;
      end
    end
    start = 1'b0;
    chk("done_within_budget", 32'(seen), 32'(1));
  endtask

  int dc, nce, nmg;
  logic [W-1:0] r_prev;
  logic [5:0] exp_ld, exp_ce, exp_busy, exp_done;

  initial begin
    isl.island_state  = '0;
    isl2.island_state = '0;
    #1;
    rst = 1'b0; start = 1'b1; seed = 16'hA5C3;
    repeat (3) begin
      tick();
      check_cycle();
    end
    start = 1'b0;
    rst = 1'b1;
    tick();
    check_cycle();

    // Default run with random island states and a start pulse during RUN.
    start = 1'b1; seed = 16'hA5C3;
    tick();
    start = 1'b0;
    check_cycle();
    chk("seed_set_out", 32'(isl.set_out), 32'(16'hA5C3));
    run_to_done(1'b1, 5, dc, nce, nmg);
    chk("done_cycle", 32'(dc), 32'(112));
    chk("ce_count", 32'(nce), 32'(100));
    chk("migrate_count", 32'(nmg), 32'(9));
    chk("set_out_kept", 32'(isl.set_out), 32'(16'hA5C3));
    r_prev = m_result;

    // Abort in the 5th RUN cycle of epoch 2.
    start = 1'b1; seed = 16'h0F0F;
    tick();
    start = 1'b0;
    check_cycle();
    for (int k = 0; k < 40 && m_t != 28; k++) begin
      isl.island_state = {$urandom, $urandom};
      tick();
      check_cycle();
    end
    chk("abort_point_ce", 32'(isl.ca_ce), 32'(1));
    chk("abort_point_epoch", 32'(epoch), 32'(2));
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_cycle();
    chk("abort_ce", 32'(isl.ca_ce), 32'(0));
    chk("abort_result", 32'(result), 32'(r_prev));
    repeat (3) begin
      tick();
      check_cycle();
    end

    // Digest of disjoint nibbles.
    isl.island_state = 64'hF000_0F00_00F0_000F;
    start = 1'b1; seed = 16'h5A5A;
    tick();
    start = 1'b0;
    check_cycle();
    run_to_done(1'b0, -1, dc, nce, nmg);
    chk("digest_ffff", 32'(result), 32'(16'hFFFF));

    // Start coincident with done, then async reset in the first MIGRATE.
    start = 1'b1; seed = 16'h3C3C;
    isl.island_state = {4{16'h1234}};
    tick();
    start = 1'b0;
    check_cycle();
    chk("restart_load", 32'(isl.ca_load), 32'(1));
    for (int k = 0; k < 20 && m_t != 2 + S; k++) begin
      tick();
      check_cycle();
    end
    chk("in_migrate", 32'(isl.migrate), 32'(1));
    #2 rst = 1'b0;
    #1;
    chk("arst_load", 32'(isl.ca_load), 32'(0));
    chk("arst_migrate", 32'(isl.migrate), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_set_out", 32'(isl.set_out), 32'(0));
    chk("arst_result", 32'(result), 32'(0));
    chk("arst_epoch", 32'(epoch), 32'(0));
    tick();
    check_cycle();
    rst = 1'b1;

    // All-equal islands cancel out.
    start = 1'b1; seed = 16'h1234;
    tick();
    start = 1'b0;
    check_cycle();
    run_to_done(1'b0, -1, dc, nce, nmg);
    chk("digest_zero", 32'(result), 32'(16'h0000));

    // Steps=3, Epochs=1: SEED, RUN x3, DONE, then done pulse.
    exp_ld = 6'b000001; exp_ce = 6'b001110; exp_busy = 6'b011111; exp_done = 6'b100000;
    isl2.island_state = 64'h0001_0002_0004_0008;
    start2 = 1'b1; seed2 = 16'hBEEF;
    tick();
    start2 = 1'b0;
    for (int c = 1; c <= 6; c++) begin
      if (c > 1) tick();
      chk("short_load", 32'(isl2.ca_load), 32'(exp_ld[c-1]));
      chk("short_ce", 32'(isl2.ca_ce), 32'(exp_ce[c-1]));
      chk("short_migrate", 32'(isl2.migrate), 32'(0));
      chk("short_busy", 32'(busy2), 32'(exp_busy[c-1]));
      chk("short_done", 32'(done2), 32'(exp_done[c-1]));
      chk("short_epoch", 32'(epoch2), 32'(0));
    end
    chk("short_set_out", 32'(isl2.set_out), 32'(16'hBEEF));
    chk("short_result", 32'(result2), 32'(16'h000F));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
